// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC generator with single-outstanding fetch and 2-entry instruction buffer
// Redirects flush the buffer and turn any in-flight request into a discard.
module pc_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic [20:0] redirect_imm,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [63:0] inst_pc,
    input  logic        inst_ready,
    output logic        misalign_err
);

    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_DRAIN} state_e;

    state_e      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic [63:0] pend_pc_q, pend_pc_d;
    logic [31:0] buf_data_q [FIFO_DEPTH];
    logic [63:0] buf_pc_q   [FIFO_DEPTH];
    logic        rd_ptr_q, wr_ptr_q;
    logic [1:0]  count_q, count_d;
    logic        misalign_q;

    logic [63:0] target;
    logic        aligned, redir, req_hs, push, pop;

    assign target  = redirect_pc + {{43{redirect_imm[20]}}, redirect_imm};
    assign aligned = (target[1:0] == 2'b00);
    assign redir   = redirect_valid && aligned;

    // Request is masked during reset so nothing is issued while state is being cleared.
    assign imem_req_valid = rst_n && (state_q == ST_RUN) && (count_q < 2'd2);
    assign imem_req_addr  = fetch_pc_q;
    assign req_hs         = imem_req_valid && imem_req_ready;

    assign push       = (state_q == ST_WAIT) && imem_rsp_valid && !redir;
    assign inst_valid = (count_q != 2'd0) && !redir;
    assign pop        = inst_valid && inst_ready;
    assign inst_data  = buf_data_q[rd_ptr_q];
    assign inst_pc    = buf_pc_q[rd_ptr_q];
    assign misalign_err = misalign_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        unique case (state_q)
            ST_RUN: begin
                if (req_hs) begin
                    state_d    = redir ? ST_DRAIN : ST_WAIT;
                    pend_pc_d  = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 64'd4;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = ST_RUN;
                end else if (redir) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (redir) begin
            fetch_pc_d = target;
        end
    end

    always_comb begin
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (redir) begin
            count_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            misalign_q <= redirect_valid && !aligned;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_data_q[i] <= 32'd0;
                buf_pc_q[i]   <= 64'd0;
            end
        end else begin
            count_q <= count_d;
            if (redir) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (push) begin
                    buf_data_q[wr_ptr_q] <= imem_rsp_data;
                    buf_pc_q[wr_ptr_q]   <= pend_pc_q;
                    wr_ptr_q             <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
            end
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, instruction buffer entries (fixed at 2 for this revision).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port redirect_valid  input  1  branch/jump taken this cycle.
REQ-006 SHALL have port redirect_pc  input  64  PC of the branch/jump instruction.
REQ-007 SHALL have port redirect_imm  input  21  signed byte offset from the branch/jump decision logic.
REQ-008 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-009 SHALL have port imem_req_addr  output  64  fetch byte address.
REQ-010 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-011 SHALL have port imem_rsp_valid  input  1  fetch data returned (one per accepted request, in order).
REQ-012 SHALL have port imem_rsp_data  input  32  instruction word.
REQ-013 SHALL have port inst_valid  output  1  buffered instruction available.
REQ-014 SHALL have port inst_data  output  32  instruction at FIFO head.
REQ-015 SHALL have port inst_pc  output  64  PC of instruction at FIFO head.
REQ-016 SHALL have port inst_ready  input  1  decode consumes head when inst_valid also high.
REQ-017 SHALL have port misalign_err  output  1  one-cycle pulse: redirect target not 4-byte aligned.

Function
REQ-018 SHALL compute target = redirect_pc + sign-extend(redirect_imm) to 64 bits, wrapping modulo 2^64.
REQ-019 SHALL implement FSM states RUN (no request outstanding), WAIT (one request outstanding, keep), DRAIN (one outstanding, discard).
REQ-020 SHALL allow at most one outstanding request; imem_req_valid=1 only in RUN with fifo_count < 2, and SHALL be held with stable address until accepted.
REQ-021 SHALL advance fetch_pc by 4 on each request handshake (wrap at 2^64) and move RUN->WAIT.
REQ-022 SHALL in WAIT, on imem_rsp_valid, push {fetch address, imem_rsp_data} into FIFO and move WAIT->RUN.
REQ-023 SHALL in DRAIN, on imem_rsp_valid, drop the data and move DRAIN->RUN.
REQ-024 SHALL on aligned redirect: set fetch_pc=target, flush FIFO to empty, force inst_valid=0 that cycle (no pop), WAIT->DRAIN, RUN stays RUN, DRAIN stays DRAIN.
REQ-025 SHALL treat redirect coincident with a request handshake as outstanding-to-discard (next state DRAIN, fetch_pc=target, not target+4).
REQ-026 SHALL treat redirect coincident with imem_rsp_valid in WAIT or DRAIN as discard; next state RUN, FIFO empty.
REQ-027 SHALL on misaligned target (target[1:0]!=0) ignore the redirect entirely and pulse misalign_err for exactly one cycle.
REQ-028 SHALL pop FIFO head when inst_valid && inst_ready; push and pop in the same cycle SHALL both take effect, count unchanged.
REQ-029 SHALL drive inst_valid = (fifo_count != 0) && !accepted-redirect; inst_data/inst_pc from head, registered FIFO storage.
REQ-030 SHALL deliver instructions in fetch order; FIFO never overflows by construction of REQ-020.
REQ-031 SHALL ignore imem_rsp_valid in RUN (protocol violation, no state change).

Reset
REQ-032 SHALL on rst_n=0 asynchronously set state=RUN, fetch_pc=RESET_PC, fifo_count=0, FIFO pointers=0.
REQ-033 SHALL hold outputs during reset: imem_req_valid=0, inst_valid=0, misalign_err=0, inst_data=0, inst_pc=0, imem_req_addr=RESET_PC.
REQ-034 SHALL discard any in-flight request state when reset asserts mid-operation; first request after release at RESET_PC.

Verification
REQ-035 SHALL cover: reset release, req_ready=1, rsp 1 cycle later, inst_ready=1 -> addresses 0x0,0x4,0x8 issued; inst_pc sequence 0x0,0x4,0x8.
REQ-036 SHALL cover: inst_ready=0 -> exactly 2 entries buffered, imem_req_valid stays 0 until a pop.
REQ-037 SHALL cover: in WAIT, redirect_pc=0x100, redirect_imm=-8 -> late response dropped, next request address 0xF8, FIFO empty.
REQ-038 SHALL cover: redirect_pc=0x40, redirect_imm=0x6 -> misalign_err one cycle, fetch stream continues unchanged.
REQ-039 SHALL cover: redirect same cycle as rsp_valid and as req handshake -> both discarded, next address = target.
REQ-040 SHALL cover: rst_n low while WAIT with 1 FIFO entry -> outputs to reset values immediately; restart fetch at RESET_PC.
